regfile_2w2r: RTL and testbench



---
 rtl/regfile_2w2r.sv | 204 ++++++++++++++++++++
 tb/tb_regfile_2w2r.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/regfile_2w2r.sv
// regfile_2w2r: register file with two write ports (execute E, memory M),
// two combinational read ports (A, B), a per-register busy scoreboard for
// pending writes, and a sticky error flag for out-of-range indices.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   srcA/srcB         read indices (4'hF = none)
//   valA/valB         read data (0 for none / out of range)
//   busyA/busyB       source register has a pending (reserved) write
//   dstE/valE         execute write (4'hF = no write)
//   dstM/valM         memory write, wins over E on the same index
//   rsv_en/rsv_dst    reserve a register as pending write
//   err/err_code      sticky error: bit0 bad read idx, bit1 bad write/reserve idx
//
// Index space is 4 bits; 4'hF is the "none" encoding, indices NREGS..14 are
// out of range and raise an error one edge later.

// One architectural register plus its busy bit.
module regfile_entry #(
  parameter int                 DATA_W  = 64,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rsv,
  output logic [DATA_W-1:0] q,
  output logic              busy
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= RST_VAL;
      busy <= 1'b0;
    end else begin
      if (we) q <= wdata;
      // A reservation in the same cycle as the retiring write belongs to a
      // newer producer, so set beats clear.
      if (rsv)     busy <= 1'b1;
      else if (we) busy <= 1'b0;
    end
  end
endmodule

// One combinational read port with optional same-cycle forwarding.
module regfile_rport #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15,
  parameter bit BYPASS = 1'b1
) (
  input  logic [3:0]                   src,
  input  logic [NREGS-1:0][DATA_W-1:0] storage,
  input  logic [NREGS-1:0]             busy_vec,
  input  logic [3:0]                   dstE,
  input  logic [DATA_W-1:0]            valE,
  input  logic [3:0]                   dstM,
  input  logic [DATA_W-1:0]            valM,
  output logic [DATA_W-1:0]            val,
  output logic                         busy,
  output logic                         bad
);
  logic in_range;

  assign in_range = (src < 4'(NREGS));
  assign bad      = (src != 4'hF) && !in_range;

  // Loop mux keeps every index of storage in range for any src value.
  always_comb begin
    val  = '0;
    busy = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (src == 4'(i)) begin
        val  = storage[i];
        busy = busy_vec[i];
      end
    end
    if (BYPASS && in_range) begin
      // M is the younger write and also wins in storage, so check it first.
      if (src == dstM)      val = valM;
      else if (src == dstE) val = valE;
      // The pending write is landing now, so the value is already usable.
      if (src == dstM || src == dstE) busy = 1'b0;
    end
  end
endmodule

module regfile_2w2r #(
  parameter int DATA_W    = 64,
  parameter int NREGS     = 15,
  parameter int STACK_TOP = 1023,
  parameter bit BYPASS    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic              rsv_en,
  input  logic [3:0]        rsv_dst,
  output logic              busyA,
  output logic              busyB,
  output logic              err,
  output logic [1:0]        err_code
);
  localparam int NUM_RD = 2;

  typedef struct packed {
    logic [3:0]        src;
  } rd_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic              busy;
    logic              bad;
  } rd_rsp_t;

  logic [NREGS-1:0][DATA_W-1:0] storage;
  logic [NREGS-1:0][DATA_W-1:0] wdata;
  logic [NREGS-1:0]             busy_vec;
  logic [NREGS-1:0]             we;
  logic [NREGS-1:0]             rsv;

  rd_req_t [NUM_RD-1:0] rd_req;
  rd_rsp_t [NUM_RD-1:0] rd_rsp;

  logic rd_bad, wr_bad;

  function automatic logic idx_bad(input logic [3:0] idx);
    return (idx != 4'hF) && (idx >= 4'(NREGS));
  endfunction

  // Register array: a matching dst index is necessarily in range.
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    localparam logic [3:0] IDX = 4'(i);
    localparam logic [DATA_W-1:0] RST_VAL =
      (i == 4) ? DATA_W'(STACK_TOP) : {DATA_W{1'b0}};

    logic hit_e, hit_m;
    assign hit_e    = (dstE == IDX);
    assign hit_m    = (dstM == IDX);
    assign we[i]    = hit_e | hit_m;
    assign wdata[i] = hit_m ? valM : valE;
    assign rsv[i]   = rsv_en && (rsv_dst == IDX);

    regfile_entry #(
      .DATA_W  (DATA_W),
      .RST_VAL (RST_VAL)
    ) u_entry (
      .clk   (clk),
      .rst   (rst),
      .we    (we[i]),
      .wdata (wdata[i]),
      .rsv   (rsv[i]),
      .q     (storage[i]),
      .busy  (busy_vec[i])
    );
  end

  assign rd_req[0].src = srcA;
  assign rd_req[1].src = srcB;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rport #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .BYPASS (BYPASS)
    ) u_rport (
      .src      (rd_req[p].src),
      .storage  (storage),
      .busy_vec (busy_vec),
      .dstE     (dstE),
      .valE     (valE),
      .dstM     (dstM),
      .valM     (valM),
      .val      (rd_rsp[p].val),
      .busy     (rd_rsp[p].busy),
      .bad      (rd_rsp[p].bad)
    );
  end

  assign valA  = rd_rsp[0].val;
  assign valB  = rd_rsp[1].val;
  assign busyA = rd_rsp[0].busy;
  assign busyB = rd_rsp[1].busy;

  assign rd_bad = rd_rsp[0].bad | rd_rsp[1].bad;
  assign wr_bad = idx_bad(dstE) | idx_bad(dstM) | (rsv_en && idx_bad(rsv_dst));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_code <= 2'b00;
    end else begin
      if (rd_bad) err_code[0] <= 1'b1;
      if (wr_bad) err_code[1] <= 1'b1;
    end
  end

  assign err = |err_code;
endmodule

// File: tb/tb_regfile_2w2r.sv
module tb_regfile_2w2r;
  localparam int DW = 64;
  localparam logic [3:0] NO = 4'hF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: defaults (NREGS=15, BYPASS=1)
  logic          rst, rsv_en, busyA, busyB, err;
  logic [3:0]    srcA, srcB, dstE, dstM, rsv_dst;
  logic [DW-1:0] valE, valM, valA, valB;
  logic [1:0]    err_code;

  // DUT 1: NREGS=8, BYPASS=0
  logic          rst2, rsv_en2, busyA2, busyB2, err2;
  logic [3:0]    srcA2, srcB2, dstE2, dstM2, rsv_dst2;
  logic [DW-1:0] valE2, valM2, valA2, valB2;
  logic [1:0]    err_code2;

  regfile_2w2r dut (
    .clk(clk), .rst(rst), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .rsv_en(rsv_en), .rsv_dst(rsv_dst), .busyA(busyA), .busyB(busyB),
    .err(err), .err_code(err_code)
  );

  regfile_2w2r #(.NREGS(8), .BYPASS(1'b0)) dut8 (
    .clk(clk), .rst(rst2), .srcA(srcA2), .srcB(srcB2), .valA(valA2), .valB(valB2),
    .dstE(dstE2), .valE(valE2), .dstM(dstM2), .valM(valM2),
    .rsv_en(rsv_en2), .rsv_dst(rsv_dst2), .busyA(busyA2), .busyB(busyB2),
    .err(err2), .err_code(err_code2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          rst;
    logic [3:0]    srcA, srcB, dstE;
    logic [DW-1:0] valE;
    logic [3:0]    dstM;
    logic [DW-1:0] valM;
    logic          rsv_en;
    logic [3:0]    rsv_dst;
    logic [DW-1:0] eA, eB;
    logic          ebA, ebB;
    logic [1:0]    ecode;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [3:0] sa, input logic [3:0] sb,
                             input logic [3:0] de, input logic [DW-1:0] ve,
                             input logic [3:0] dm, input logic [DW-1:0] vm,
                             input logic re, input logic [3:0] rd,
                             input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                             input logic ba, input logic bb, input logic [1:0] ec);
    vec_t t;
    t.rst = r; t.srcA = sa; t.srcB = sb; t.dstE = de; t.valE = ve;
    t.dstM = dm; t.valM = vm; t.rsv_en = re; t.rsv_dst = rd;
    t.eA = ea; t.eB = eb; t.ebA = ba; t.ebB = bb; t.ecode = ec;
    return t;
  endfunction

  vec_t tbl[19];

  initial begin
    // Each row: inputs for one cycle, expected outputs before that cycle's edge.
    //          rst srcA srcB dstE valE dstM valM rsv rdst  eA    eB   bA bB ec
    tbl[0]  = v(0, 4,   0,   NO,  0,   NO,  0,   0, NO,   1023, 0,    0, 0, 0); // reset state
    tbl[1]  = v(0, 2,   NO,  2,   5,   2,   9,   0, NO,   9,    0,    0, 0, 0); // E/M same idx, M wins
    tbl[2]  = v(0, 2,   4,   NO,  0,   NO,  0,   0, NO,   9,    1023, 0, 0, 0);
    tbl[3]  = v(0, 3,   NO,  NO,  0,   NO,  0,   1, 3,    0,    0,    0, 0, 0); // reserve r3
    tbl[4]  = v(0, 3,   3,   NO,  0,   NO,  0,   0, NO,   0,    0,    1, 1, 0);
    tbl[5]  = v(0, 3,   3,   3,   44,  NO,  0,   0, NO,   44,   44,   0, 0, 0); // write masks busy
    tbl[6]  = v(0, 3,   NO,  NO,  0,   NO,  0,   0, NO,   44,   0,    0, 0, 0);
    tbl[7]  = v(0, 6,   NO,  NO,  0,   6,   66,  1, 6,    66,   0,    0, 0, 0); // set + clear same cycle
    tbl[8]  = v(0, 6,   6,   NO,  0,   NO,  0,   0, NO,   66,   66,   1, 1, 0); // set wins
    tbl[9]  = v(0, 7,   8,   7,   11,  8,   22,  0, NO,   11,   22,   0, 0, 0); // both ports distinct
    tbl[10] = v(0, 7,   8,   NO,  0,   NO,  0,   0, NO,   11,   22,   0, 0, 0);
    tbl[11] = v(0, 5,   6,   5,   3,   NO,  0,   0, NO,   3,    66,   0, 1, 0);
    tbl[12] = v(1, 1,   4,   1,   7,   NO,  0,   1, 2,    7,    1023, 0, 0, 0); // write under reset
    tbl[13] = v(0, 1,   3,   NO,  0,   NO,  0,   0, NO,   0,    0,    0, 0, 0); // reset dominated
    tbl[14] = v(0, 6,   2,   NO,  0,   NO,  0,   0, NO,   0,    0,    0, 0, 0); // busy cleared
    tbl[15] = v(0, 14,  NO,  14,  171, NO,  0,   0, NO,   171,  0,    0, 0, 0); // top valid index
    tbl[16] = v(0, 14,  5,   NO,  0,   NO,  0,   0, NO,   171,  0,    0, 0, 0);
    tbl[17] = v(0, NO,  NO,  NO,  99,  NO,  88,  1, NO,   0,    0,    0, 0, 0); // all-none no-op
    tbl[18] = v(0, 0,   NO,  NO,  0,   NO,  0,   0, NO,   0,    0,    0, 0, 0);

    rst  = 1; srcA = NO; srcB = NO; dstE = NO; dstM = NO; valE = 0; valM = 0; rsv_en = 0; rsv_dst = NO;
    rst2 = 1; srcA2 = NO; srcB2 = NO; dstE2 = NO; dstM2 = NO; valE2 = 0; valM2 = 0; rsv_en2 = 0; rsv_dst2 = NO;
    @(posedge clk); @(posedge clk);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; srcA = tbl[i].srcA; srcB = tbl[i].srcB;
      dstE = tbl[i].dstE; valE = tbl[i].valE; dstM = tbl[i].dstM; valM = tbl[i].valM;
      rsv_en = tbl[i].rsv_en; rsv_dst = tbl[i].rsv_dst;
      rst2 = 0;
      #2;
      chk($sformatf("v%0d valA", i), valA, tbl[i].eA);
      chk($sformatf("v%0d valB", i), valB, tbl[i].eB);
      chk($sformatf("v%0d busyA", i), 64'(busyA), 64'(tbl[i].ebA));
      chk($sformatf("v%0d busyB", i), 64'(busyB), 64'(tbl[i].ebB));
      chk($sformatf("v%0d err_code", i), 64'(err_code), 64'(tbl[i].ecode));
      chk($sformatf("v%0d err", i), 64'(err), 64'(|tbl[i].ecode));
    end
    @(negedge clk);
    rst = 0; srcA = NO; srcB = NO; dstE = NO; dstM = NO; rsv_en = 0;

    // NREGS=8, BYPASS=0 instance: range errors and unforwarded reads.
    @(negedge clk); srcA2 = 4; srcB2 = 7; #2;
    chk("n8 r4 reset", valA2, 1023);
    chk("n8 r7 reset", valB2, 0);
    chk("n8 err reset", 64'(err2), 0);
    @(negedge clk); srcA2 = 10; srcB2 = NO; #2;
    chk("n8 bad rd val", valA2, 0);
    chk("n8 bad rd busy", 64'(busyA2), 0);
    chk("n8 err pre-edge", 64'(err2), 0);
    @(negedge clk); srcA2 = NO; #2;
    chk("n8 err_code rd", 64'(err_code2), 1);
    chk("n8 err rd", 64'(err2), 1);
    repeat (10) @(negedge clk);
    #2 chk("n8 err sticky", 64'(err_code2), 1);

    @(negedge clk); dstE2 = 2; valE2 = 5; srcA2 = 2; #2;
    chk("n8 no bypass", valA2, 0);
    @(negedge clk); dstE2 = NO; #2;
    chk("n8 write lands", valA2, 5);

    @(negedge clk); rsv_en2 = 1; rsv_dst2 = 3; srcA2 = 3; #2;
    chk("n8 busy pre", 64'(busyA2), 0);
    @(negedge clk); rsv_en2 = 0; rsv_dst2 = NO; dstE2 = 3; valE2 = 77; #2;
    chk("n8 busy unmasked", 64'(busyA2), 1);
    chk("n8 old value", valA2, 0);
    @(negedge clk); dstE2 = NO; #2;
    chk("n8 busy cleared", 64'(busyA2), 0);
    chk("n8 r3 value", valA2, 77);

    @(negedge clk); dstM2 = 9; valM2 = 1; #2;
    chk("n8 bad wr pre", 64'(err_code2), 1);
    @(negedge clk); dstM2 = NO; #2;
    chk("n8 bad wr code", 64'(err_code2), 3);

    @(negedge clk); rst2 = 1; rsv_en2 = 1; rsv_dst2 = 5; srcA2 = 5;
    @(negedge clk); rst2 = 0; rsv_en2 = 0; rsv_dst2 = NO; #2;
    chk("n8 rst clears err", 64'(err_code2), 0);
    chk("n8 rst beats rsv", 64'(busyA2), 0);
    srcA2 = 3; #1;
    chk("n8 rst clears r3", valA2, 0);

    @(negedge clk); rsv_en2 = 1; rsv_dst2 = 12;
    @(negedge clk); rsv_en2 = 0; rsv_dst2 = NO; #2;
    chk("n8 bad rsv code", 64'(err_code2), 2);
    chk("n8 bad rsv err", 64'(err2), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
